// File: rtl/rob_commit.sv
// Reorder buffer: dual allocate, dual tag-matched writeback, dual in-order commit, commit-time branch flush.
// Define ROB_FWD_EN to build the operand-bypass lookup ports (fwd_tag_i / fwd_ready_o / fwd_value_o).
package rob_commit_pkg;
  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned ROB_TAG_W = ROB_IDX_W + 1;

  typedef struct packed {
    logic                 is_valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [31:0]          result;
    logic                 is_branch_established;
    logic [31:0]          jumped_to;
  } ex_result_t;
endpackage

module rob_commit
  import rob_commit_pkg::*;
#(
  // Must equal ROB_IDX_W so the result tag field lines up with {phase, index}.
  parameter int unsigned BUF_SIZE_LOG = ROB_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  alloc_valid_i,
  input  logic [1:0][4:0]             alloc_rd_i,
  output logic                        alloc_ready_o,
  output logic [1:0][BUF_SIZE_LOG:0]  alloc_tag_o,
  input  ex_result_t                  results_i [2],
  output logic [1:0]                  commit_valid_o,
  output logic [1:0][4:0]             commit_rd_o,
  output logic [1:0][31:0]            commit_value_o,
  output logic                        redirect_valid_o,
  output logic [31:0]                 redirect_pc_o,
  output logic                        is_tag_flooded_o
`ifdef ROB_FWD_EN
  ,
  input  logic [1:0][BUF_SIZE_LOG:0]  fwd_tag_i,
  output logic [1:0]                  fwd_ready_o,
  output logic [1:0][31:0]            fwd_value_o
`endif
);

  localparam int unsigned DEPTH = 1 << BUF_SIZE_LOG;

  typedef logic [BUF_SIZE_LOG-1:0] idx_t;
  typedef logic [BUF_SIZE_LOG:0]   cnt_t;

  logic [DEPTH-1:0] valid_q, done_q, phase_q, taken_q;
  logic [4:0]       rd_q     [DEPTH];
  logic [31:0]      value_q  [DEPTH];
  logic [31:0]      target_q [DEPTH];

  idx_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;
  logic tail_phase_q, tail_phase_d;

  logic [1:0]       commit_valid_q;
  logic [1:0][4:0]  commit_rd_q;
  logic [1:0][31:0] commit_value_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;

  idx_t        head1, tail1;
  logic        tail1_phase;
  logic [1:0]  alloc_acc;
  idx_t        slot_idx [2];
  logic [1:0]  slot_ph;
  idx_t        wb_idx [2];
  logic [1:0]  wb_hit;
  logic        c0, c1, flush;
  logic [31:0] flush_pc;
  cnt_t        n_alloc, n_commit, tail_sum;

  assign alloc_ready_o = (count_q <= cnt_t'(DEPTH - 2));
  assign alloc_acc     = alloc_valid_i & {2{alloc_ready_o}};

  assign tail1       = tail_q + idx_t'(1);
  assign tail1_phase = tail_phase_q ^ (tail_q == idx_t'(DEPTH - 1));

  assign alloc_tag_o[0]   = {tail_phase_q, tail_q};
  assign alloc_tag_o[1]   = {tail1_phase, tail1};
  assign is_tag_flooded_o = tail_phase_q;

  // A lone slot-1 request is stored at the tail, i.e. under alloc_tag_o[0].
  always_comb begin
    slot_idx[0] = tail_q;
    slot_ph[0]  = tail_phase_q;
    slot_idx[1] = alloc_acc[0] ? tail1 : tail_q;
    slot_ph[1]  = alloc_acc[0] ? tail1_phase : tail_phase_q;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wb_idx[i] = results_i[i].tag[BUF_SIZE_LOG-1:0];
      wb_hit[i] = results_i[i].is_valid && valid_q[wb_idx[i]] &&
                  (phase_q[wb_idx[i]] == results_i[i].tag[BUF_SIZE_LOG]);
    end
  end

  // A taken branch in slot 0 blocks slot 1, so at most one redirect source per cycle.
  assign head1    = head_q + idx_t'(1);
  assign c0       = valid_q[head_q] & done_q[head_q];
  assign c1       = c0 & ~taken_q[head_q] & valid_q[head1] & done_q[head1];
  assign flush    = (c0 & taken_q[head_q]) | (c1 & taken_q[head1]);
  assign flush_pc = (c0 & taken_q[head_q]) ? target_q[head_q] : target_q[head1];

  assign n_alloc  = cnt_t'(alloc_acc[0]) + cnt_t'(alloc_acc[1]);
  assign n_commit = cnt_t'(c0) + cnt_t'(c1);
  assign tail_sum = {1'b0, tail_q} + n_alloc;

  // NOTE: every always_comb output gets a value on every path before any
  // conditional override, otherwise synthesis infers a latch.
  always_comb begin
    head_d       = head_q + idx_t'(n_commit);
    tail_d       = tail_sum[BUF_SIZE_LOG-1:0];
    tail_phase_d = tail_phase_q ^ tail_sum[BUF_SIZE_LOG];
    count_d      = count_q + n_alloc - n_commit;
    if (flush) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      tail_phase_d = tail_phase_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      tail_phase_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      tail_phase_q <= tail_phase_d;
    end
  end

  // Later statements win: slot-1 writeback overrides slot 0, commit clears valid last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      phase_q <= '0;
      taken_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (alloc_acc[s]) begin
          valid_q[slot_idx[s]] <= 1'b1;
          done_q[slot_idx[s]]  <= 1'b0;
          taken_q[slot_idx[s]] <= 1'b0;
          phase_q[slot_idx[s]] <= slot_ph[s];
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (wb_hit[i]) begin
          done_q[wb_idx[i]]  <= 1'b1;
          taken_q[wb_idx[i]] <= results_i[i].is_branch_established;
        end
      end
      if (c0) valid_q[head_q] <= 1'b0;
      if (c1) valid_q[head1]  <= 1'b0;
    end
  end

  // NOTE: payload storage has no reset; it is only read through the valid/done
  // flags, which are reset, so clearing it would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int s = 0; s < 2; s++) begin
        if (alloc_acc[s]) rd_q[slot_idx[s]] <= alloc_rd_i[s];
      end
      for (int i = 0; i < 2; i++) begin
        if (wb_hit[i]) begin
          value_q[wb_idx[i]]  <= results_i[i].result;
          target_q[wb_idx[i]] <= results_i[i].jumped_to;
        end
      end
    end
  end

  // rd/value hold their last retired contents while the strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid_q   <= '0;
      commit_rd_q      <= '0;
      commit_value_q   <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      commit_valid_q   <= {c1, c0};
      redirect_valid_q <= flush;
      if (c0) begin
        commit_rd_q[0]    <= rd_q[head_q];
        commit_value_q[0] <= value_q[head_q];
      end
      if (c1) begin
        commit_rd_q[1]    <= rd_q[head1];
        commit_value_q[1] <= value_q[head1];
      end
      if (flush) redirect_pc_q <= flush_pc;
    end
  end

  assign commit_valid_o   = commit_valid_q;
  assign commit_rd_o      = commit_rd_q;
  assign commit_value_o   = commit_value_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

`ifdef ROB_FWD_EN
  idx_t       fwd_idx [2];
  logic [1:0] fwd_hit;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      fwd_idx[k]     = fwd_tag_i[k][BUF_SIZE_LOG-1:0];
      fwd_hit[k]     = valid_q[fwd_idx[k]] && done_q[fwd_idx[k]] &&
                       (phase_q[fwd_idx[k]] == fwd_tag_i[k][BUF_SIZE_LOG]);
      fwd_value_o[k] = fwd_hit[k] ? value_q[fwd_idx[k]] : 32'h0;
    end
  end

  assign fwd_ready_o = fwd_hit;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: directed stimulus pushes expected retire events, a negedge monitor pops them.
// Exercises the ROB_FWD_EN bypass ports only when that macro is defined.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [1:0]       alloc_valid;
  logic [1:0][4:0]  alloc_rd;
  logic             alloc_ready;
  logic [1:0][4:0]  alloc_tag;
  ex_result_t       results [2];
  logic [1:0]       commit_valid;
  logic [1:0][4:0]  commit_rd;
  logic [1:0][31:0] commit_value;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             is_tag_flooded;
`ifdef ROB_FWD_EN
  logic [1:0][4:0]  fwd_tag;
  logic [1:0]       fwd_ready;
  logic [1:0][31:0] fwd_value;
`endif

  rob_commit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_valid_i    (alloc_valid),
    .alloc_rd_i       (alloc_rd),
    .alloc_ready_o    (alloc_ready),
    .alloc_tag_o      (alloc_tag),
    .results_i        (results),
    .commit_valid_o   (commit_valid),
    .commit_rd_o      (commit_rd),
    .commit_value_o   (commit_value),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .is_tag_flooded_o (is_tag_flooded)
`ifdef ROB_FWD_EN
    ,
    .fwd_tag_i        (fwd_tag),
    .fwd_ready_o      (fwd_ready),
    .fwd_value_o      (fwd_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cv;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        redir;
    logic [31:0] pc;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] cv, input logic [4:0] rd0, input logic [31:0] v0,
                      input logic [4:0] rd1, input logic [31:0] v1,
                      input logic redir, input logic [31:0] pc);
    exp_t e;
    e.cv = cv; e.rd0 = rd0; e.v0 = v0; e.rd1 = rd1; e.v1 = v1; e.redir = redir; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic set_wb(input int s, input logic [4:0] tag, input logic [31:0] val,
                        input logic br, input logic [31:0] tgt);
    results[s].is_valid              = 1'b1;
    results[s].tag                   = tag;
    results[s].result                = val;
    results[s].is_branch_established = br;
    results[s].jumped_to             = tgt;
  endtask

  // Inputs live for exactly one clock edge.
  task automatic step();
    @(posedge clk);
    #1;
    alloc_valid = '0;
    results[0]  = '0;
    results[1]  = '0;
  endtask

  task automatic alloc(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1);
    alloc_valid = v;
    alloc_rd[0] = rd0;
    alloc_rd[1] = rd1;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
    check({tag, "_alloc_tag0"}, 32'(alloc_tag[0]), 32'h00);
    check({tag, "_alloc_tag1"}, 32'(alloc_tag[1]), 32'h01);
    check({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
    check({tag, "_commit_rd"}, 32'(commit_rd), 32'd0);
    check({tag, "_commit_value0"}, commit_value[0], 32'd0);
    check({tag, "_commit_value1"}, commit_value[1], 32'd0);
    check({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    check({tag, "_tag_flooded"}, 32'(is_tag_flooded), 32'd0);
  endtask

  // Any retire strobe or redirect must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (commit_valid != 2'b00 || redirect_valid)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_retire: got cv=%b rd0=%0d v0=0x%0h redirect=%b, expected no event",
                 commit_valid, commit_rd[0], commit_value[0], redirect_valid);
      end else begin
        mon_e = sb.pop_front();
        check("mon_commit_valid", 32'(commit_valid), 32'(mon_e.cv));
        check("mon_redirect_valid", 32'(redirect_valid), 32'(mon_e.redir));
        if (mon_e.redir) check("mon_redirect_pc", redirect_pc, mon_e.pc);
        if (mon_e.cv[0]) begin
          check("mon_rd0", 32'(commit_rd[0]), 32'(mon_e.rd0));
          check("mon_value0", commit_value[0], mon_e.v0);
        end
        if (mon_e.cv[1]) begin
          check("mon_rd1", 32'(commit_rd[1]), 32'(mon_e.rd1));
          check("mon_value1", commit_value[1], mon_e.v1);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    alloc_valid = '0;
    alloc_rd    = '0;
    results[0]  = '0;
    results[1]  = '0;
`ifdef ROB_FWD_EN
    fwd_tag     = '0;
`endif

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Out-of-order completion, paired in-order retire
    alloc(2'b11, 5'd3, 5'd4);
    check("pair_tag0", 32'(alloc_tag[0]), 32'h02);
    check("pair_tag1", 32'(alloc_tag[1]), 32'h03);
    set_wb(0, 5'h01, 32'h0000_BEEF, 1'b0, 32'h0);
    step();
    set_wb(0, 5'h00, 32'h0000_1234, 1'b0, 32'h0);
    push(2'b11, 5'd3, 32'h0000_1234, 5'd4, 32'h0000_BEEF, 1'b0, 32'h0);
    step();
    step();
    step();

    // Fill to 14: tail wraps to index 0 with phase 1
    for (int p = 0; p < 7; p++) alloc(2'b11, 5'(10 + 2 * p), 5'(11 + 2 * p));
    check("fill14_ready", 32'(alloc_ready), 32'd1);
    check("wrap_tag0", 32'(alloc_tag[0]), 32'h10);
    check("wrap_tag1", 32'(alloc_tag[1]), 32'h11);
    check("wrap_flooded", 32'(is_tag_flooded), 32'd1);
    alloc(2'b01, 5'd20, 5'd0);
    check("fill15_ready", 32'(alloc_ready), 32'd0);
    alloc(2'b11, 5'd30, 5'd31);
    check("full_reject_tag0", 32'(alloc_tag[0]), 32'h11);
    check("full_reject_ready", 32'(alloc_ready), 32'd0);
    set_wb(0, 5'h02, 32'h22, 1'b0, 32'h0);
    set_wb(1, 5'h03, 32'h33, 1'b0, 32'h0);
    push(2'b11, 5'd10, 32'h22, 5'd11, 32'h33, 1'b0, 32'h0);
    step();
    check("full_before_commit", 32'(alloc_ready), 32'd0);
    step();
    check("ready_after_commit", 32'(alloc_ready), 32'd1);

    // Same-index double writeback (slot 1 wins), then bypass lookup
    set_wb(0, 5'h04, 32'h0000_AAAA, 1'b0, 32'h0);
    set_wb(1, 5'h04, 32'h0000_4444, 1'b0, 32'h0);
    push(2'b01, 5'd12, 32'h0000_4444, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    set_wb(0, 5'h05, 32'hA5A5_A5A5, 1'b0, 32'h0);
    push(2'b01, 5'd13, 32'hA5A5_A5A5, 5'd0, 32'h0, 1'b0, 32'h0);
`ifdef ROB_FWD_EN
    fwd_tag[0] = 5'h05;
    fwd_tag[1] = 5'h15;
    #1;
    check("fwd_same_cycle_ready", 32'(fwd_ready), 32'd0);
`endif
    step();
`ifdef ROB_FWD_EN
    check("fwd_ready", 32'(fwd_ready), 32'b01);
    check("fwd_value0", fwd_value[0], 32'hA5A5_A5A5);
    check("fwd_value1_wrong_phase", fwd_value[1], 32'h0);
`endif
    step();

    // Taken branch at head blocks the done younger entry and flushes
    set_wb(0, 5'h07, 32'h77, 1'b0, 32'h0);
    step();
    set_wb(0, 5'h06, 32'h0000_6666, 1'b1, 32'h0000_0100);
    step();
    alloc_valid = 2'b11;
    alloc_rd[0] = 5'd25;
    alloc_rd[1] = 5'd26;
    push(2'b01, 5'd14, 32'h0000_6666, 5'd0, 32'h0, 1'b1, 32'h0000_0100);
    step();
    check("flush_tag0", 32'(alloc_tag[0]), 32'h10);
    check("flush_tag1", 32'(alloc_tag[1]), 32'h11);
    check("flush_ready", 32'(alloc_ready), 32'd1);
    check("flush_phase_kept", 32'(is_tag_flooded), 32'd1);
    step();
    check("redirect_pulse_end", 32'(redirect_valid), 32'd0);

    // Stale-phase writeback is dropped; the matching one retires
    alloc(2'b01, 5'd9, 5'd0);
    set_wb(0, 5'h00, 32'h0000_DEAD, 1'b0, 32'h0);
    step();
    step();
    step();
    set_wb(0, 5'h10, 32'h0000_900D, 1'b0, 32'h0);
    push(2'b01, 5'd9, 32'h0000_900D, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    step();

    // Asynchronous reset while a retire strobe is high
    alloc(2'b11, 5'd17, 5'd18);
    set_wb(0, 5'h11, 32'h0000_1111, 1'b0, 32'h0);
    step();
    push(2'b01, 5'd17, 32'h0000_1111, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_wb(0, 5'h12, 32'h0000_2222, 1'b0, 32'h0);
    step();
    step();
    step();

    check("scoreboard_pending", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer and in-order commit stage, directly downstream of the execute stage.
- Allocates entries for up to 2 dispatched instructions per cycle and hands out tags.
- Captures the 2 execute results per cycle by tag.
- Retires up to 2 completed entries per cycle in program order to the register file, and performs commit-time branch recovery (full flush plus PC redirect).

Parameters:
BUF_SIZE_LOG, 4, log2 of entry count; depth = 2**BUF_SIZE_LOG (16).

Ports:
clk  input  1  clock.
rst_n  input  1  reset, active-low.
alloc_valid  input  2  per-slot dispatch request; slot 0 is older.
alloc_rd  input  2x5  destination register per slot (0 = no write).
alloc_ready  output  1  at least 2 free entries.
alloc_tag  output  2x(BUF_SIZE_LOG+1)  tag for each slot: {phase, index}.
results  input  ex_result_t[2]  execute results; uses is_valid, tag, result, is_branch_established, jumped_to.
commit_valid  output  2  registered retire strobes; slot 0 is older.
commit_rd  output  2x5  retired destination register.
commit_value  output  2x32  retired result.
redirect_valid  output  1  registered 1-cycle flush/redirect pulse.
redirect_pc  output  32  target PC when redirect_valid = 1.
is_tag_flooded  output  1  current tail phase bit.

Behaviour:
- **Storage.** Circular buffer with head, tail and count (count is BUF_SIZE_LOG+1 bits). Each entry holds: valid, done, phase, rd, value, taken, target.
- **Reset** (async, rst_n = 0):
  - head = tail = count = 0; all valid/done cleared; phase bits = 0.
  - commit_valid = 0, commit_rd = 0, commit_value = 0, redirect_valid = 0, redirect_pc = 0.
  - Reset mid-operation discards all entries immediately.
- **Allocation:**
  - alloc_ready = (depth − count) ≥ 2, combinational from registered state.
  - alloc_tag[0] = {phase_of(tail), tail}; alloc_tag[1] = the next index, with phase toggled if the index wraps to 0.
  - An accepted request (alloc_valid & alloc_ready) writes valid = 1, done = 0, taken = 0 at the clock edge.
  - If only slot 1 is valid, it takes the tail index.
  - The tail phase toggles on each wrap from depth−1 to 0. is_tag_flooded equals the tail's phase bit.
- **Writeback:**
  - For each i with results[i].is_valid, the entry at index = tag[BUF_SIZE_LOG-1:0] is written only if entry.valid and entry.phase == tag MSB.
  - Writes set done = 1, value = result, taken = is_branch_established, target = jumped_to.
  - Mismatched or stale writes are dropped silently.
  - Both slots writing the same index in one cycle: slot 1 wins.
- **Commit:** evaluated on registered state each cycle.
  - c0 = entry[head].valid & done.
  - c1 = c0 & !entry[head].taken & entry[head+1].valid & done.
  - At the edge:
    - commit_valid <= {c1, c0}; rd/value are registered alongside.
    - commit_rd is forced to 0 when the stored rd = 0.
    - Committed entries are invalidated; head advances by c0 + c1.
  - A result written at edge E is retired at edge E+1 at the earliest; commit_valid is high in the cycle after E+1.
- **Branch recovery:**
  - If a committed entry has taken = 1 (at most one per cycle, by the c1 rule), at the same edge:
    - redirect_valid <= 1 and redirect_pc <= target.
    - All entries are invalidated; head = tail = count = 0 and phase bits are retained.
    - Same-cycle allocations and writebacks are discarded.
  - The taken branch itself still commits its rd/value (link register).
  - redirect_valid returns to 0 the next edge unless another taken branch commits.
- **Simultaneous alloc + commit:** count_next = count + allocs − commits. Wrap-around of head/tail is modulo depth.
- **Full:** count = depth−1 or depth → alloc_ready = 0, while commits continue.
- **Empty:** commit_valid = 0 and no state change.

Optional Feature:
ROB_FWD_EN
- Defined: adds ports fwd_tag input 2x(BUF_SIZE_LOG+1), fwd_ready output 2, fwd_value output 2x32.
  - Combinational lookup for dispatch operand bypass.
  - fwd_ready[k] = entry valid & done & phase match; fwd_value = entry value, else 0.
  - A writeback in the same cycle is not visible until the next cycle.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: alloc_ready = 1, alloc_tag = {0x00, 0x01}, all outputs 0; pulse rst_n low mid-traffic → count 0 and commit_valid 0 in the same cycle.
- Allocate rd = 3 (tag 0) and rd = 4 (tag 1); write tag 1 = 0xBEEF first, then tag 0 = 0x1234 one cycle later → single cycle with commit_valid = 2'b11, rd {3,4}, values {0x1234, 0xBEEF}.
- Allocate 14 entries without writeback → alloc_ready = 0 at count 15 (after 15) / 14 boundary; commit 2 → alloc_ready returns; tags wrap to phase 1 at index 0 and is_tag_flooded = 1.
- Taken branch at tag 2 with jumped_to = 0x0000_0100 and done younger tag 3 → commit of tag 2 only; next cycle redirect_valid = 1, redirect_pc = 0x100, count = 0, tag 3 never commits.
- Stale writeback with phase 0 to an index now holding phase 1 → dropped, entry stays not-done, no commit.
- With ROB_FWD_EN: after writeback of tag 5 = 0xA5A5_A5A5, fwd_tag = 5 → next cycle fwd_ready = 1, fwd_value = 0xA5A5_A5A5; wrong phase → fwd_ready = 0.
